thread_regfile: RTL and testbench

//   Per-thread 16 x 8-bit register file; one instance per ALU/LSU lane in each core.

---
 rtl/thread_regfile.sv | 134 +++++++++++++
 tb/tb_thread_regfile.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/thread_regfile.sv
// ----------------------------------------------------------------------------
// thread_regfile
//   Register file for one thread lane: 16 registers, each DATA_BITS wide.
//   - R0-R12 are general purpose.
//   - R13 follows block_id on every enabled cycle (%blockIdx).
//   - R14 is the constant THREADS_PER_BLOCK (%blockDim).
//   - R15 is the constant THREAD_ID (%threadIdx).
//
//   In REQUEST the rs/rt operands are latched from the register contents
//   before the clock edge. In UPDATE rd is written with the ALU result, the
//   LSU load data or the decoded immediate.
//
//   Optional build macro: REGFILE_ZERO_REG_EN
//   - When defined, R0 always reads as 0 and writes to R0 are dropped.
//
// Ports
//   clk, reset                clock; synchronous active-low reset
//   enable                    lane active; when 0 all state is frozen
//   block_id                  block index, mirrored into R13
//   core_state                core pipeline state; REQUEST and UPDATE are used
//   decoded_rs/rt/rd_address  source and destination register indices
//   decoded_reg_write_enable  the current instruction writes rd
//   decoded_reg_input_mux     00=ALU, 01=LSU, 10=immediate, 11=reserved
//   decoded_immediate         CONST immediate
//   alu_out, lsu_out          writeback sources
//   rs, rt                    registered operands
// ----------------------------------------------------------------------------
module thread_regfile #(
   parameter int DATA_BITS         = 8,
   parameter int THREADS_PER_BLOCK = 4,
   parameter int THREAD_ID         = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [7:0]           block_id,
   input  logic [2:0]           core_state,
   input  logic [3:0]           decoded_rs_address,
   input  logic [3:0]           decoded_rt_address,
   input  logic [3:0]           decoded_rd_address,
   input  logic                 decoded_reg_write_enable,
   input  logic [1:0]           decoded_reg_input_mux,
   input  logic [DATA_BITS-1:0] decoded_immediate,
   input  logic [DATA_BITS-1:0] alu_out,
   input  logic [DATA_BITS-1:0] lsu_out,
   output logic [DATA_BITS-1:0] rs,
   output logic [DATA_BITS-1:0] rt
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_FETCH   = 3'b001,
      ST_DECODE  = 3'b010,
      ST_REQUEST = 3'b011,
      ST_WAIT    = 3'b100,
      ST_EXECUTE = 3'b101,
      ST_UPDATE  = 3'b110,
      ST_DONE    = 3'b111
   } core_state_e;

   localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL = DATA_BITS'(THREADS_PER_BLOCK);
   localparam logic [DATA_BITS-1:0] THREAD_ID_VAL = DATA_BITS'(THREAD_ID);

   // Only R0-R13 need storage. R14 and R15 are constants and are supplied
   // directly in the read view below.
   logic [DATA_BITS-1:0] regs_q [0:13];
   logic [DATA_BITS-1:0] regs_d [0:13];
   logic [DATA_BITS-1:0] rs_q, rs_d;
   logic [DATA_BITS-1:0] rt_q, rt_d;

   logic [DATA_BITS-1:0] rf_view [0:15];
   logic [DATA_BITS-1:0] wr_data;
   logic                 wr_ok;

   // Architectural view of all 16 registers as the operand reads see them.
   always_comb begin
      for (int i = 0; i < 14; i++) rf_view[i] = regs_q[i];
      rf_view[14] = BLOCK_DIM_VAL;
      rf_view[15] = THREAD_ID_VAL;
`ifdef REGFILE_ZERO_REG_EN
      rf_view[0]  = '0;
`endif
   end

   // Writeback source select. The reserved mux code suppresses the write.
   always_comb begin
      wr_data = '0;
      wr_ok   = 1'b1;
      case (decoded_reg_input_mux)
         2'b00:   wr_data = alu_out;
         2'b01:   wr_data = lsu_out;
         2'b10:   wr_data = decoded_immediate;
         default: wr_ok   = 1'b0;
      endcase
   end

   always_comb begin
      regs_d = regs_q;
      rs_d   = rs_q;
      rt_d   = rt_q;
      if (enable) begin
         regs_d[13] = DATA_BITS'(block_id);
         if (core_state == ST_REQUEST) begin
            rs_d = rf_view[decoded_rs_address];
            rt_d = rf_view[decoded_rt_address];
         end
         if (core_state == ST_UPDATE && decoded_reg_write_enable && wr_ok) begin
            // Only R0-R12 can be written, so R13-R15 can never be corrupted.
`ifdef REGFILE_ZERO_REG_EN
            for (int i = 1; i < 13; i++)
`else
            for (int i = 0; i < 13; i++)
`endif
               if (decoded_rd_address == 4'(i)) regs_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 14; i++) regs_q[i] <= '0;
         rs_q <= '0;
         rt_q <= '0;
      end else begin
         regs_q <= regs_d;
         rs_q   <= rs_d;
         rt_q   <= rt_d;
      end
   end

   assign rs = rs_q;
   assign rt = rt_q;

endmodule

// File: tb/tb_thread_regfile.sv
module tb_thread_regfile;

   localparam logic [2:0] S_IDLE = 3'b000, S_REQUEST = 3'b011, S_WAIT = 3'b100,
                          S_EXECUTE = 3'b101, S_UPDATE = 3'b110;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic [7:0] block_id = 8'd0;
   logic [2:0] core_state = S_IDLE;
   logic [3:0] rs_a = 4'd0, rt_a = 4'd0, rd_a = 4'd0;
   logic       we = 1'b0;
   logic [1:0] mux = 2'b00;
   logic [7:0] imm = 8'd0, alu = 8'd0, lsu = 8'd0;
   logic [7:0] rs, rt;

   int errors = 0;
   int checks = 0;

   thread_regfile #(.DATA_BITS(8), .THREADS_PER_BLOCK(4), .THREAD_ID(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
      .core_state(core_state), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
      .decoded_rd_address(rd_a), .decoded_reg_write_enable(we),
      .decoded_reg_input_mux(mux), .decoded_immediate(imm),
      .alu_out(alu), .lsu_out(lsu), .rs(rs), .rt(rt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One UPDATE cycle with write enable set.
   task automatic upd(input logic [3:0] d, input logic [1:0] m, input logic [7:0] i,
                      input logic [7:0] a, input logic [7:0] l);
      core_state = S_UPDATE; we = 1'b1; rd_a = d; mux = m; imm = i; alu = a; lsu = l;
      tick();
      we = 1'b0; core_state = S_IDLE;
   endtask

   // One REQUEST cycle; the operands are visible right after the edge.
   task automatic req(input logic [3:0] a, input logic [3:0] b);
      core_state = S_REQUEST; rs_a = a; rt_a = b;
      tick();
      core_state = S_WAIT;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++; if (rs !== 8'h00) begin errors++; $display("FAIL reset_rs got=%h exp=%h", rs, 8'h00); end
      checks++; if (rt !== 8'h00) begin errors++; $display("FAIL reset_rt got=%h exp=%h", rt, 8'h00); end
      req(4'd14, 4'd15);
      checks++; if (rs !== 8'h04) begin errors++; $display("FAIL reset_r14 got=%h exp=%h", rs, 8'h04); end
      checks++; if (rt !== 8'h02) begin errors++; $display("FAIL reset_r15 got=%h exp=%h", rt, 8'h02); end
   endtask

   task automatic test_const();
      upd(4'd3, 2'b10, 8'h5A, 8'h00, 8'h00);
      req(4'd3, 4'd0);
      checks++; if (rs !== 8'h5A) begin errors++; $display("FAIL const_r3 got=%h exp=%h", rs, 8'h5A); end
      // Outside REQUEST the operands hold, and outside UPDATE nothing is written.
      core_state = S_EXECUTE; rs_a = 4'd15; we = 1'b1; rd_a = 4'd3; mux = 2'b10; imm = 8'h99;
      tick();
      we = 1'b0;
      checks++; if (rs !== 8'h5A) begin errors++; $display("FAIL hold_rs got=%h exp=%h", rs, 8'h5A); end
      req(4'd0, 4'd3);
      checks++; if (rt !== 8'h5A) begin errors++; $display("FAIL no_write_exec got=%h exp=%h", rt, 8'h5A); end
   endtask

   task automatic test_alu_lsu();
      upd(4'd5, 2'b00, 8'h00, 8'h11, 8'hEE);
      upd(4'd6, 2'b01, 8'h00, 8'hEE, 8'hC3);
      req(4'd5, 4'd6);
      checks++; if (rs !== 8'h11) begin errors++; $display("FAIL alu_r5 got=%h exp=%h", rs, 8'h11); end
      checks++; if (rt !== 8'hC3) begin errors++; $display("FAIL lsu_r6 got=%h exp=%h", rt, 8'hC3); end
   endtask

   task automatic test_readonly();
      upd(4'd15, 2'b10, 8'hFF, 8'h00, 8'h00);
      upd(4'd14, 2'b00, 8'h00, 8'hEE, 8'h00);
      upd(4'd2, 2'b10, 8'h22, 8'h00, 8'h00);
      upd(4'd2, 2'b11, 8'h66, 8'h66, 8'h66);
      req(4'd14, 4'd15);
      checks++; if (rs !== 8'h04) begin errors++; $display("FAIL ro_r14 got=%h exp=%h", rs, 8'h04); end
      checks++; if (rt !== 8'h02) begin errors++; $display("FAIL ro_r15 got=%h exp=%h", rt, 8'h02); end
      req(4'd2, 4'd2);
      checks++; if (rs !== 8'h22) begin errors++; $display("FAIL mux11_r2 got=%h exp=%h", rs, 8'h22); end
      block_id = 8'd7;
      core_state = S_IDLE;
      tick();
      req(4'd13, 4'd0);
      checks++; if (rs !== 8'h07) begin errors++; $display("FAIL r13_block got=%h exp=%h", rs, 8'h07); end
   endtask

   task automatic test_back_to_back();
      upd(4'd7, 2'b10, 8'hA5, 8'h00, 8'h00);
      req(4'd7, 4'd7);
      checks++; if (rs !== 8'hA5) begin errors++; $display("FAIL b2b_r7 got=%h exp=%h", rs, 8'hA5); end
      upd(4'd7, 2'b01, 8'h00, 8'h00, 8'h3C);
      req(4'd7, 4'd6);
      checks++; if (rs !== 8'h3C) begin errors++; $display("FAIL b2b_r7_lsu got=%h exp=%h", rs, 8'h3C); end
      checks++; if (rt !== 8'hC3) begin errors++; $display("FAIL b2b_r6 got=%h exp=%h", rt, 8'hC3); end
   endtask

   task automatic test_freeze();
      enable = 1'b0;
      req(4'd3, 4'd5);
      checks++; if (rs !== 8'h3C) begin errors++; $display("FAIL frz_rs got=%h exp=%h", rs, 8'h3C); end
      checks++; if (rt !== 8'hC3) begin errors++; $display("FAIL frz_rt got=%h exp=%h", rt, 8'hC3); end
      upd(4'd5, 2'b10, 8'h77, 8'h00, 8'h00);
      block_id = 8'd9;
      tick();
      block_id = 8'd7;
      enable = 1'b1;
      req(4'd5, 4'd13);
      checks++; if (rs !== 8'h11) begin errors++; $display("FAIL frz_r5 got=%h exp=%h", rs, 8'h11); end
      checks++; if (rt !== 8'h07) begin errors++; $display("FAIL frz_r13 got=%h exp=%h", rt, 8'h07); end
   endtask

   task automatic test_reset_mid_update();
      core_state = S_UPDATE; we = 1'b1; rd_a = 4'd3; mux = 2'b10; imm = 8'h44;
      reset = 1'b0;
      tick();
      reset = 1'b1; we = 1'b0; core_state = S_IDLE;
      checks++; if (rs !== 8'h00) begin errors++; $display("FAIL mid_rst_rs got=%h exp=%h", rs, 8'h00); end
      checks++; if (rt !== 8'h00) begin errors++; $display("FAIL mid_rst_rt got=%h exp=%h", rt, 8'h00); end
      req(4'd14, 4'd3);
      checks++; if (rs !== 8'h04) begin errors++; $display("FAIL mid_rst_r14 got=%h exp=%h", rs, 8'h04); end
      checks++; if (rt !== 8'h00) begin errors++; $display("FAIL mid_rst_r3 got=%h exp=%h", rt, 8'h00); end
      req(4'd5, 4'd13);
      checks++; if (rs !== 8'h00) begin errors++; $display("FAIL mid_rst_r5 got=%h exp=%h", rs, 8'h00); end
      checks++; if (rt !== 8'h07) begin errors++; $display("FAIL mid_rst_r13 got=%h exp=%h", rt, 8'h07); end
   endtask

   task automatic test_zero_reg();
      logic [7:0] exp_r0;
`ifdef REGFILE_ZERO_REG_EN
      exp_r0 = 8'h00;
`else
      exp_r0 = 8'h33;
`endif
      upd(4'd0, 2'b10, 8'h33, 8'h00, 8'h00);
      req(4'd0, 4'd14);
      checks++; if (rs !== exp_r0) begin errors++; $display("FAIL zero_r0 got=%h exp=%h", rs, exp_r0); end
      checks++; if (rt !== 8'h04) begin errors++; $display("FAIL zero_r14 got=%h exp=%h", rt, 8'h04); end
   endtask

   initial begin
      test_reset();
      test_const();
      test_alu_lsu();
      test_readonly();
      test_back_to_back();
      test_freeze();
      test_reset_mid_update();
      test_zero_reg();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
